// File: rtl/sobel_grad_sq.sv
// Streaming 3x3 Sobel front end: two line buffers, window, |Gx|/|Gy|, scaled squares, saturated sum.
// Define SOBEL_ROUND_EN for round-half-up magnitude scaling; truncation otherwise.
module sobel_grad_sq #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_pix,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_R,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic en, accept;
    logic at_last_col, at_last_row;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [7:0]    lb0_q [IMG_W];
    logic [7:0]    lb1_q [IMG_W];

    logic [2:0][2:0][7:0] win_q, win_d;
    logic v0_q, v0_d, last0_q, last0_d;

    logic [9:0] gx_pos, gx_neg, gy_pos, gy_neg;
    logic [9:0] gxa_q, gxa_d, gya_q, gya_d;
    logic v1_q, v1_d, last1_q, last1_d;

    logic [7:0]  gx_s, gy_s;
    logic [15:0] gx_sq, gy_sq;
    logic [16:0] sum_s;
    logic [15:0] r_q, r_d;
    logic ov_q, ov_d, ol_q, ol_d;

    // One global enable: the whole pipeline freezes only when a held result is refused.
    assign en        = !ov_q || out_ready;
    assign in_ready  = en;
    assign accept    = in_valid && en;
    assign out_R     = r_q;
    assign out_valid = ov_q;
    assign out_last  = ol_q;

    assign at_last_col = (col_q == CW'(IMG_W - 1));
    assign at_last_row = (row_q == RW'(IMG_H - 1));

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        v0_d    = v0_q;
        last0_d = last0_q;
        if (en) begin
            v0_d    = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
            last0_d = accept && at_last_col && at_last_row;
        end
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_q[col_q];
            win_d[1][2] = lb0_q[col_q];
            win_d[2][2] = in_pix;
            if (at_last_col) begin
                col_d = '0;
                row_d = at_last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Magnitudes are formed as |pos - neg| so no signed arithmetic is needed.
    always_comb begin
        gx_pos = 10'(win_q[0][2]) + {1'b0, win_q[1][2], 1'b0} + 10'(win_q[2][2]);
        gx_neg = 10'(win_q[0][0]) + {1'b0, win_q[1][0], 1'b0} + 10'(win_q[2][0]);
        gy_pos = 10'(win_q[2][0]) + {1'b0, win_q[2][1], 1'b0} + 10'(win_q[2][2]);
        gy_neg = 10'(win_q[0][0]) + {1'b0, win_q[0][1], 1'b0} + 10'(win_q[0][2]);
        gxa_d   = gxa_q;
        gya_d   = gya_q;
        v1_d    = v1_q;
        last1_d = last1_q;
        if (en) begin
            v1_d    = v0_q;
            last1_d = last0_q;
            gxa_d   = (gx_pos >= gx_neg) ? gx_pos - gx_neg : gx_neg - gx_pos;
            gya_d   = (gy_pos >= gy_neg) ? gy_pos - gy_neg : gy_neg - gy_pos;
        end
    end

    always_comb begin
`ifdef SOBEL_ROUND_EN
        gx_s = 8'((gxa_q + 10'd2) >> 2);
        gy_s = 8'((gya_q + 10'd2) >> 2);
`else
        gx_s = 8'(gxa_q >> 2);
        gy_s = 8'(gya_q >> 2);
`endif
        gx_sq = 16'(gx_s) * 16'(gx_s);
        gy_sq = 16'(gy_s) * 16'(gy_s);
        sum_s = 17'(gx_sq) + 17'(gy_sq);
        r_d   = r_q;
        ov_d  = ov_q;
        ol_d  = ol_q;
        if (en) begin
            ov_d = v1_q;
            ol_d = v1_q && last1_q;
            if (v1_q) begin
                r_d = sum_s[16] ? 16'hFFFF : sum_s[15:0];
            end
        end
    end

    // Line buffer contents are never reset; interior windows only read rows of the current frame.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= in_pix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            v0_q    <= 1'b0;
            last0_q <= 1'b0;
            gxa_q   <= '0;
            gya_q   <= '0;
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            r_q     <= '0;
            ov_q    <= 1'b0;
            ol_q    <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            v0_q    <= v0_d;
            last0_q <= last0_d;
            gxa_q   <= gxa_d;
            gya_q   <= gya_d;
            v1_q    <= v1_d;
            last1_q <= last1_d;
            r_q     <= r_d;
            ov_q    <= ov_d;
            ol_q    <= ol_d;
        end
    end

endmodule
